// File: rtl/stk_mc_engine.sv
// rtl/stk_mc_engine.sv - multi-channel stack/queue engine with round-robin admission
// Admit -> memory -> writeback pipeline; one response per admitted command.
module stk_mc_engine #(
   parameter int ENGS_N = 4,
   parameter int W      = 128,
   parameter int DEPTH  = 16,
   parameter int MODE   = 0
) (
   input  logic                                clk,
   input  logic                                arst,
   input  logic [ENGS_N-1:0]                   i_cmd_vld,
   input  logic [2*ENGS_N-1:0]                 i_cmd_opcode,
   input  logic [ENGS_N*W-1:0]                 i_cmd_dat,
   output logic [ENGS_N-1:0]                   o_cmd_ack,
   output logic [ENGS_N-1:0]                   o_rsp_vld,
   output logic [W-1:0]                        o_rsp_dat,
   output logic [1:0]                          o_rsp_status,
   output logic [ENGS_N*$clog2(DEPTH+1)-1:0]   o_occ
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int GW = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;
   localparam int AW = GW + PW;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [1:0] OP_PUSH  = 2'd0;
   localparam logic [1:0] OP_POP   = 2'd1;
   localparam logic [1:0] OP_PEEK  = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   localparam logic [1:0] ST_OK    = 2'd0;
   localparam logic [1:0] ST_FULL  = 2'd1;
   localparam logic [1:0] ST_EMPTY = 2'd2;

   logic [CW-1:0] cnt    [ENGS_N];
   logic [PW-1:0] wr_ptr [ENGS_N];
   logic [PW-1:0] rd_ptr [ENGS_N];
   logic [W-1:0]  mem    [ENGS_N*DEPTH];

   logic [GW-1:0] rr_ptr;
   logic [GW-1:0] rr_nxt;
   logic [GW-1:0] gnt_idx;
   logic          gnt_any;
   logic          adm;
   int            scan_idx;

   // Round-robin scan starting at rr_ptr; idle channels are skipped.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_idx = 0;
      for (int i = 0; i < ENGS_N; i++) begin
         scan_idx = (int'(rr_ptr) + i) % ENGS_N;
         if (!gnt_any && i_cmd_vld[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx[GW-1:0];
         end
      end
   end

   assign adm    = gnt_any & ~arst;
   assign rr_nxt = (int'(gnt_idx) == ENGS_N-1) ? '0 : gnt_idx + 1'b1;

   always_comb begin
      o_cmd_ack = '0;
      if (adm) o_cmd_ack[gnt_idx] = 1'b1;
   end

   logic [1:0]    ad_op;
   logic [W-1:0]  ad_dat;
   logic [CW-1:0] cur_cnt;
   logic [PW-1:0] cur_wr;
   logic [PW-1:0] cur_rd;
   logic [PW-1:0] lifo_top;
   logic [CW-1:0] nxt_cnt;
   logic [PW-1:0] nxt_wr;
   logic [PW-1:0] nxt_rd;
   logic [PW-1:0] ad_slot;
   logic [1:0]    ad_status;
   logic          ad_wr;
   logic          ad_rd;
   logic [AW-1:0] ad_addr;

   assign ad_op    = i_cmd_opcode[2*gnt_idx +: 2];
   assign ad_dat   = i_cmd_dat[W*gnt_idx +: W];
   assign cur_cnt  = cnt[gnt_idx];
   assign cur_wr   = wr_ptr[gnt_idx];
   assign cur_rd   = rd_ptr[gnt_idx];
   assign lifo_top = cur_cnt[PW-1:0] - 1'b1;
   assign ad_addr  = {gnt_idx, ad_slot};

   always_comb begin
      ad_status = ST_OK;
      ad_wr     = 1'b0;
      ad_rd     = 1'b0;
      ad_slot   = '0;
      nxt_cnt   = cur_cnt;
      nxt_wr    = cur_wr;
      nxt_rd    = cur_rd;
      case (ad_op)
         OP_PUSH: begin
            if (cur_cnt == FULL_CNT) begin
               ad_status = ST_FULL;
            end else begin
               ad_wr   = 1'b1;
               ad_slot = (MODE != 0) ? cur_wr : cur_cnt[PW-1:0];
               nxt_cnt = cur_cnt + 1'b1;
               nxt_wr  = cur_wr + 1'b1;
            end
         end
         OP_POP, OP_PEEK: begin
            if (cur_cnt == '0) begin
               ad_status = ST_EMPTY;
            end else begin
               ad_rd   = 1'b1;
               ad_slot = (MODE != 0) ? cur_rd : lifo_top;
               if (ad_op == OP_POP) begin
                  nxt_cnt = cur_cnt - 1'b1;
                  nxt_rd  = cur_rd + 1'b1;
               end
            end
         end
         OP_CLEAR: begin
            nxt_cnt = '0;
            nxt_wr  = '0;
            nxt_rd  = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rr_ptr <= '0;
         for (int e = 0; e < ENGS_N; e++) begin
            cnt[e]    <= '0;
            wr_ptr[e] <= '0;
            rd_ptr[e] <= '0;
         end
      end else if (adm) begin
         rr_ptr          <= rr_nxt;
         cnt[gnt_idx]    <= nxt_cnt;
         wr_ptr[gnt_idx] <= nxt_wr;
         rd_ptr[gnt_idx] <= nxt_rd;
      end
   end

   // Written on the admission edge so a read admitted next cycle sees it.
   always_ff @(posedge clk) begin
      if (adm && ad_wr) mem[ad_addr] <= ad_dat;
   end

   logic          s1_vld;
   logic [GW-1:0] s1_ch;
   logic [1:0]    s1_status;
   logic          s1_rd;
   logic [AW-1:0] s1_addr;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         s1_vld    <= 1'b0;
         s1_ch     <= '0;
         s1_status <= ST_OK;
         s1_rd     <= 1'b0;
         s1_addr   <= '0;
      end else begin
         s1_vld <= adm;
         if (adm) begin
            s1_ch     <= gnt_idx;
            s1_status <= ad_status;
            s1_rd     <= ad_rd;
            s1_addr   <= ad_addr;
         end
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         o_rsp_vld    <= '0;
         o_rsp_dat    <= '0;
         o_rsp_status <= ST_OK;
      end else begin
         o_rsp_vld <= '0;
         if (s1_vld) begin
            o_rsp_vld[s1_ch] <= 1'b1;
            o_rsp_dat        <= s1_rd ? mem[s1_addr] : '0;
            o_rsp_status     <= s1_status;
         end
      end
   end

   always_comb begin
      o_occ = '0;
      for (int e = 0; e < ENGS_N; e++) o_occ[CW*e +: CW] = cnt[e];
   end

endmodule

// File: tb/tb_stk_mc_engine.sv
// tb/tb_stk_mc_engine.sv - directed bench for stk_mc_engine in LIFO and FIFO modes
// Two instances (MODE 0 and MODE 1) share clock and reset.
module tb_stk_mc_engine;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int D  = 4;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic arst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    l_vld, f_vld;
   logic [2*N-1:0]  l_op, f_op;
   logic [N*W-1:0]  l_dat, f_dat;
   logic [N-1:0]    l_ack, f_ack, l_rvld, f_rvld;
   logic [W-1:0]    l_rdat, f_rdat;
   logic [1:0]      l_rst, f_rst;
   logic [N*CW-1:0] l_occ, f_occ;

   int checks = 0;
   int errors = 0;

   stk_mc_engine #(.ENGS_N(N), .W(W), .DEPTH(D), .MODE(0)) dut_l (
      .clk(clk), .arst(arst), .i_cmd_vld(l_vld), .i_cmd_opcode(l_op), .i_cmd_dat(l_dat),
      .o_cmd_ack(l_ack), .o_rsp_vld(l_rvld), .o_rsp_dat(l_rdat), .o_rsp_status(l_rst), .o_occ(l_occ));

   stk_mc_engine #(.ENGS_N(N), .W(W), .DEPTH(D), .MODE(1)) dut_f (
      .clk(clk), .arst(arst), .i_cmd_vld(f_vld), .i_cmd_opcode(f_op), .i_cmd_dat(f_dat),
      .o_cmd_ack(f_ack), .o_rsp_vld(f_rvld), .o_rsp_dat(f_rdat), .o_rsp_status(f_rst), .o_occ(f_occ));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] occ_of(input logic fifo, input int ch);
      return fifo ? f_occ[CW*ch +: CW] : l_occ[CW*ch +: CW];
   endfunction

   // Single command on one channel: ack in cycle t, response checked in t+2.
   task automatic do_cmd(input string tag, input logic fifo, input int ch, input logic [1:0] op,
                         input logic [W-1:0] dat, input logic [1:0] exp_st, input logic [W-1:0] exp_dat);
      logic [N-1:0] onehot;
      onehot = '0;
      onehot[ch] = 1'b1;
      @(posedge clk); #1;
      if (fifo) begin
         f_vld[ch] = 1'b1; f_op[2*ch +: 2] = op; f_dat[W*ch +: W] = dat;
      end else begin
         l_vld[ch] = 1'b1; l_op[2*ch +: 2] = op; l_dat[W*ch +: W] = dat;
      end
      #4;
      chk({tag, "_ack"}, fifo ? f_ack : l_ack, onehot);
      @(posedge clk); #1;
      l_vld = '0;
      f_vld = '0;
      @(posedge clk); #4;
      chk({tag, "_rvld"}, fifo ? f_rvld : l_rvld, onehot);
      chk({tag, "_status"}, fifo ? f_rst : l_rst, exp_st);
      chk({tag, "_dat"}, fifo ? f_rdat : l_rdat, exp_dat);
   endtask

   initial begin
      l_vld = '0; l_op = '0; l_dat = '0;
      f_vld = '0; f_op = '0; f_dat = '0;

      // Reset: outputs clear, no ack even with every channel requesting.
      l_vld = '1;
      f_vld = '1;
      repeat (2) @(posedge clk);
      #4;
      chk("rst_ack_l", l_ack, 4'h0);
      chk("rst_ack_f", f_ack, 4'h0);
      chk("rst_rvld", l_rvld, 4'h0);
      chk("rst_dat", l_rdat, 32'h0);
      chk("rst_status", l_rst, 2'd0);
      chk("rst_occ_l", l_occ, 12'h0);
      chk("rst_occ_f", f_occ, 12'h0);
      l_vld = '0;
      f_vld = '0;
      @(posedge clk); #1;
      arst = 1'b0;

      // Arbitration: all channels push for 8 cycles.
      @(posedge clk); #1;
      l_vld = '1;
      l_op  = '0;
      for (int c = 0; c < N; c++) l_dat[W*c +: W] = 32'h100 + c;
      for (int k = 0; k < 10; k++) begin
         logic [N-1:0] exp_ack;
         logic [N-1:0] exp_rv;
         #4;
         exp_ack = '0;
         exp_rv  = '0;
         exp_ack[k % 4] = 1'b1;
         if (k >= 2) exp_rv[(k - 2) % 4] = 1'b1;
         if (k < 8) chk($sformatf("arb_ack%0d", k), l_ack, exp_ack);
         if (k >= 2) begin
            chk($sformatf("arb_rvld%0d", k), l_rvld, exp_rv);
            chk($sformatf("arb_st%0d", k), l_rst, 2'd0);
         end
         @(posedge clk); #1;
         if (k == 7) l_vld = '0;
      end
      for (int c = 0; c < N; c++) chk($sformatf("arb_occ%0d", c), occ_of(1'b0, c), 3'd2);

      for (int c = 0; c < N; c++) do_cmd($sformatf("clr%0d", c), 1'b0, c, 2'd3, 32'h0, 2'd0, 32'h0);
      chk("clr_occ", l_occ, 12'h0);

      // LIFO channel 1
      do_cmd("l_push_a", 1'b0, 1, 2'd0, 32'hA, 2'd0, 32'h0);
      do_cmd("l_push_b", 1'b0, 1, 2'd0, 32'hB, 2'd0, 32'h0);
      do_cmd("l_push_c", 1'b0, 1, 2'd0, 32'hC, 2'd0, 32'h0);
      chk("l_occ3", occ_of(1'b0, 1), 3'd3);
      do_cmd("l_pop_c", 1'b0, 1, 2'd1, 32'h0, 2'd0, 32'hC);
      do_cmd("l_pop_b", 1'b0, 1, 2'd1, 32'h0, 2'd0, 32'hB);
      do_cmd("l_pop_a", 1'b0, 1, 2'd1, 32'h0, 2'd0, 32'hA);
      chk("l_occ0", occ_of(1'b0, 1), 3'd0);

      // Empty channel 2, then CLEAR on channel 3
      do_cmd("e_pop", 1'b0, 2, 2'd1, 32'h0, 2'd2, 32'h0);
      do_cmd("e_peek", 1'b0, 2, 2'd2, 32'h0, 2'd2, 32'h0);
      chk("e_occ", occ_of(1'b0, 2), 3'd0);
      do_cmd("c_push1", 1'b0, 3, 2'd0, 32'h31, 2'd0, 32'h0);
      do_cmd("c_push2", 1'b0, 3, 2'd0, 32'h32, 2'd0, 32'h0);
      do_cmd("c_push3", 1'b0, 3, 2'd0, 32'h33, 2'd0, 32'h0);
      do_cmd("c_peek", 1'b0, 3, 2'd2, 32'h0, 2'd0, 32'h33);
      chk("c_occ3", occ_of(1'b0, 3), 3'd3);
      do_cmd("c_clear", 1'b0, 3, 2'd3, 32'h0, 2'd0, 32'h0);
      chk("c_occ0", occ_of(1'b0, 3), 3'd0);
      do_cmd("c_peek_e", 1'b0, 3, 2'd2, 32'h0, 2'd2, 32'h0);

      // Back-to-back PUSH then PEEK on channel 0
      @(posedge clk); #1;
      l_vld[0] = 1'b1; l_op[1:0] = 2'd0; l_dat[31:0] = 32'h55;
      #4;
      chk("bb_ack_push", l_ack, 4'h1);
      @(posedge clk); #1;
      l_op[1:0] = 2'd2;
      #4;
      chk("bb_ack_peek", l_ack, 4'h1);
      @(posedge clk); #1;
      l_vld = '0;
      #4;
      chk("bb_push_rvld", l_rvld, 4'h1);
      chk("bb_push_st", l_rst, 2'd0);
      @(posedge clk); #4;
      chk("bb_peek_rvld", l_rvld, 4'h1);
      chk("bb_peek_st", l_rst, 2'd0);
      chk("bb_peek_dat", l_rdat, 32'h55);
      chk("bb_occ", occ_of(1'b0, 0), 3'd1);

      // FIFO channel 0 with wrap
      for (int v = 1; v <= 4; v++) do_cmd($sformatf("f_push%0d", v), 1'b1, 0, 2'd0, 32'(v), 2'd0, 32'h0);
      chk("f_occ4", occ_of(1'b1, 0), 3'd4);
      do_cmd("f_push_full", 1'b1, 0, 2'd0, 32'h99, 2'd1, 32'h0);
      chk("f_occ_full", occ_of(1'b1, 0), 3'd4);
      do_cmd("f_pop1", 1'b1, 0, 2'd1, 32'h0, 2'd0, 32'h1);
      do_cmd("f_pop2", 1'b1, 0, 2'd1, 32'h0, 2'd0, 32'h2);
      do_cmd("f_push5", 1'b1, 0, 2'd0, 32'h5, 2'd0, 32'h0);
      do_cmd("f_push6", 1'b1, 0, 2'd0, 32'h6, 2'd0, 32'h0);
      do_cmd("f_peek3", 1'b1, 0, 2'd2, 32'h0, 2'd0, 32'h3);
      for (int v = 3; v <= 6; v++) do_cmd($sformatf("f_pop%0d", v), 1'b1, 0, 2'd1, 32'h0, 2'd0, 32'(v));
      chk("f_occ_end", occ_of(1'b1, 0), 3'd0);

      // Reset one cycle after a POP is acked on channel 1
      do_cmd("r_push", 1'b0, 1, 2'd0, 32'h77, 2'd0, 32'h0);
      @(posedge clk); #1;
      l_vld[1] = 1'b1; l_op[3:2] = 2'd1;
      #4;
      chk("r_pop_ack", l_ack, 4'h2);
      @(posedge clk); #1;
      l_vld = '0;
      arst = 1'b1;
      #3;
      chk("r_rvld_a", l_rvld, 4'h0);
      @(posedge clk); #4;
      chk("r_rvld_b", l_rvld, 4'h0);
      @(posedge clk); #1;
      arst = 1'b0;
      #3;
      chk("r_rvld_c", l_rvld, 4'h0);
      @(posedge clk); #4;
      chk("r_rvld_d", l_rvld, 4'h0);
      chk("r_occ_l", l_occ, 12'h0);
      chk("r_occ_f", f_occ, 12'h0);
      @(posedge clk); #1;
      l_vld = 4'b0101;
      l_op  = '0;
      #4;
      chk("r_next_gnt", l_ack, 4'h1);
      @(posedge clk); #1;
      l_vld = '0;
      @(posedge clk); #4;
      chk("r_next_rvld", l_rvld, 4'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stk_mc_engine.md
# stk_mc_engine

Parametrised multi-channel stack/queue engine, the successor to the single-configuration stack pipeline. It serves ENGS_N independent command channels with a round-robin admission arbiter and keeps one statically partitioned storage region per channel. A compile-time MODE selects LIFO (stack) or FIFO (queue) semantics. A fixed three-stage pipeline (admit, memory, writeback) returns one response per admitted command.

## Interface
Parameters:
- ENGS_N, 4, number of command channels (≥1)
- W, 128, data width in bits
- DEPTH, 16, entries per channel (power of two, ≥2)
- MODE, 0, 0 = LIFO (stack), 1 = FIFO (queue)

Ports:
- clk  in  1  sole clock, all state rising-edge
- arst  in  1  asynchronous, active-high reset
- i_cmd_vld  in  ENGS_N  per-channel command valid
- i_cmd_opcode  in  ENGS_N×2  per-channel opcode: 0 PUSH, 1 POP, 2 PEEK, 3 CLEAR
- i_cmd_dat  in  ENGS_N×W  per-channel push data
- o_cmd_ack  out  ENGS_N  one-hot (or zero) admission grant, combinational
- o_rsp_vld  out  ENGS_N  one-hot response valid, registered
- o_rsp_dat  out  W  response data, registered
- o_rsp_status  out  2  0 OK, 1 FULL, 2 EMPTY, registered
- o_occ  out  ENGS_N×$clog2(DEPTH+1)  per-channel occupancy, registered

## Operation
- Admit (AD): the round-robin arbiter grants at most one i_cmd_vld per cycle and asserts o_cmd_ack for that channel in the same cycle. A command is consumed when vld & ack. Priority starts at the channel after the last granted one. After reset, priority starts at channel 0.
- Per-channel state (cnt, plus wr/rd pointers in FIFO mode) is updated on the admission edge. No channel-to-channel or back-to-back hazards exist.
- Storage: one ENGS_N*DEPTH×W array. Channel e owns addresses e*DEPTH … e*DEPTH+DEPTH-1.
- LIFO behaviour:
  - PUSH writes slot cnt, then cnt+1.
  - POP reads slot cnt-1, then cnt-1.
  - PEEK reads slot cnt-1 and leaves cnt unchanged.
- FIFO behaviour:
  - PUSH writes slot wr, then wr = (wr+1) mod DEPTH and cnt+1.
  - POP reads slot rd, then rd = (rd+1) mod DEPTH and cnt-1.
  - PEEK reads slot rd.
  - Pointer wrap is natural $clog2(DEPTH)-bit overflow.
- CLEAR sets cnt, wr and rd to 0. Array contents are untouched. Status OK, dat 0.
- PUSH when cnt==DEPTH: no write, no state change, status FULL, dat 0.
- POP or PEEK when cnt==0: no state change, status EMPTY, dat 0.
- Successful PUSH: status OK, dat 0.
- Successful POP or PEEK: status OK, dat = stored word.
- The array write for PUSH occurs on the admission edge. A read admitted in the following cycle observes the new data.
- The arbiter skips idle channels. Commands for one channel are served in order.
- o_occ[e] mirrors cnt[e].

## Timing
- Command admitted (ack) in cycle t; o_rsp_vld for that channel is high in cycle t+2 for exactly one cycle.
- Throughput: one command per cycle across all channels, with no stalls or backpressure on responses.
- o_occ reflects an admission from cycle t+1 onward.
- Reset values: o_rsp_vld 0, o_rsp_dat 0, o_rsp_status 0, o_occ all 0.
- State reset: all cnt/wr/rd 0, and the round-robin pointer set so that channel 0 has priority.
- While arst is high, o_cmd_ack is 0.
- Reset mid-operation: in-flight commands (AD→MEM, MEM→WRBK) are dropped, and no response is produced for them after release.
- o_rsp_dat and o_rsp_status hold their last value when o_rsp_vld is 0. Checkers sample them only under valid.
- Simultaneous vld on all channels, held continuously: grants rotate 0,1,2,3,0,… with one grant per cycle.

## Test plan
- LIFO, ENGS_N=4, DEPTH=4:
  - Channel 1 pushes 0xA, 0xB, 0xC, then pops 3 times → responses OK/0, OK/0, OK/0, then OK/0xC, OK/0xB, OK/0xA, each at ack+2.
  - Final o_occ[1]=0.
- FIFO wrap, DEPTH=4:
  - Channel 0 runs push 1..4, pop ×2, push 5,6, pop ×4 → pops return 1, 2, 3, 4, 5, 6.
  - Push 5,6 and pops 3..6 exercise wr/rd wrap.
  - A fifth push before any pop returns FULL with o_occ[0]=4 unchanged.
- Boundaries:
  - POP and PEEK on empty channel 2 → EMPTY, dat 0, o_occ unchanged.
  - CLEAR after 3 pushes → OK, o_occ 0.
  - A subsequent PEEK → EMPTY.
- Arbitration:
  - All 4 channels hold vld with PUSH for 8 cycles → ack order 0,1,2,3,0,1,2,3.
  - o_rsp_vld one-hot in the same order, 2 cycles later.
  - o_occ = 2 on every channel.
- Back-to-back hazard: PUSH 0x55 in cycle t, PEEK on the same channel in t+1 → PEEK response OK/0x55 at t+3.
- Reset mid-flight:
  - Assert arst one cycle after acking a POP → no o_rsp_vld during or after reset.
  - All o_occ = 0.
  - The next grant goes to channel 0.
